// File: rtl/eth_rx_pkt_gate_pkg.sv
// Shared definitions for the ethernet receive packet gate:
// tuser field positions, FIFO entry layout and write-FSM states.
`timescale 1ns/1ps
package eth_rx_pkt_gate_pkg;

  localparam int TUSER_ERR_BIT    = 3;
  localparam int TUSER_NBYTES_MSB = 2;
  localparam int TUSER_NBYTES_LSB = 0;
  localparam int DATA_W           = 64;
  localparam int ENTRY_W          = 69;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_t;

  // Entry layout is {tlast, tuser[3:0], tdata}; the error bit is never stored as 1.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic last,
                                                    input logic [2:0] nbytes,
                                                    input logic [DATA_W-1:0] data);
    return {last, 1'b0, nbytes, data};
  endfunction

endpackage

// File: rtl/eth_rx_pkt_gate_ram_2port.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enabled read so the read register can double as an output holding stage.
`timescale 1ns/1ps
module ram_2port #(
  parameter int AW = 11,
  parameter int DW = 69
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_pkt_gate.sv
// Packet gate for the XGE MAC receive stream: frames are buffered and only
// released once their last beat arrives clean and the whole frame fit.
`timescale 1ns/1ps
module eth_rx_pkt_gate
  import eth_rx_pkt_gate_pkg::*;
#(
  parameter int SIZE = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] s_tdata,
  input  logic [3:0]  s_tuser,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [3:0]  m_tuser,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  input  logic        clear_stats,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_err_cnt,
  output logic [31:0] drop_ovf_cnt
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  wr_state_t          state, state_next;
  logic [SIZE-1:0]    wr_ptr, wr_ptr_next;
  logic [SIZE-1:0]    wr_commit, wr_commit_next;
  logic [SIZE-1:0]    rd_ptr;
  logic               full, wr_en, rd_en, avail;
  logic               inc_pkt, inc_err, inc_ovf;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign s_tready = ~reset;
  assign full     = (wr_ptr + ONE) == rd_ptr;
  assign avail    = rd_ptr != wr_commit;
  assign rd_en    = avail && (!m_tvalid || m_tready);
  assign wr_entry = pack_entry(s_tlast, s_tuser[TUSER_NBYTES_MSB:TUSER_NBYTES_LSB], s_tdata);

  ram_2port #(.AW(SIZE), .DW(ENTRY_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  assign m_tdata = rd_entry[DATA_W-1:0];
  assign m_tuser = rd_entry[DATA_W+3:DATA_W];
  assign m_tlast = rd_entry[ENTRY_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ACCEPT;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      state     <= state_next;
      wr_ptr    <= wr_ptr_next;
      wr_commit <= wr_commit_next;
    end
  end

  // Any dropped frame rewinds the speculative pointer to the last commit point.
  always_comb begin
    state_next     = state;
    wr_ptr_next    = wr_ptr;
    wr_commit_next = wr_commit;
    wr_en          = 1'b0;
    inc_pkt        = 1'b0;
    inc_err        = 1'b0;
    inc_ovf        = 1'b0;
    if (s_tvalid) begin
      case (state)
        ST_ACCEPT: begin
          if (!full) begin
            if (!s_tlast) begin
              wr_en       = 1'b1;
              wr_ptr_next = wr_ptr + ONE;
            end else if (!s_tuser[TUSER_ERR_BIT]) begin
              wr_en          = 1'b1;
              wr_ptr_next    = wr_ptr + ONE;
              wr_commit_next = wr_ptr + ONE;
              inc_pkt        = 1'b1;
            end else begin
              wr_ptr_next = wr_commit;
              inc_err     = 1'b1;
            end
          end else if (s_tlast) begin
            wr_ptr_next = wr_commit;
            inc_ovf     = 1'b1;
          end else begin
            state_next = ST_DROP;
          end
        end
        ST_DROP: begin
          if (s_tlast) begin
            wr_ptr_next = wr_commit;
            inc_ovf     = 1'b1;
            state_next  = ST_ACCEPT;
          end
        end
        default: state_next = ST_ACCEPT;
      endcase
    end
  end

  // The RAM read register is the output stage; it only reloads when empty or consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      m_tvalid <= 1'b0;
    end else if (rd_en) begin
      rd_ptr   <= rd_ptr + ONE;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      pkt_cnt      <= '0;
      drop_err_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else begin
      if (inc_pkt) pkt_cnt      <= pkt_cnt + 32'd1;
      if (inc_err) drop_err_cnt <= drop_err_cnt + 32'd1;
      if (inc_ovf) drop_ovf_cnt <= drop_ovf_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_pkt_gate.sv
// Self-checking bench for eth_rx_pkt_gate: directed scenarios plus random
// traffic, compared every cycle against a queue-based frame model.
`timescale 1ns/1ps
module tb_eth_rx_pkt_gate;

  localparam int SIZE = 4;
  localparam int CAP  = (1 << SIZE) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [3:0]  s_tuser = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [3:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        clear_stats = 1'b0;
  logic [31:0] pkt_cnt, drop_err_cnt, drop_ovf_cnt;

  eth_rx_pkt_gate #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tdata      (s_tdata),
    .s_tuser      (s_tuser),
    .s_tlast      (s_tlast),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .clear_stats  (clear_stats),
    .pkt_cnt      (pkt_cnt),
    .drop_err_cnt (drop_err_cnt),
    .drop_ovf_cnt (drop_ovf_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: committed words waiting in RAM, words of the frame being
  // received, and the single output holding stage.
  logic [68:0] q[$];
  logic [68:0] pend[$];
  logic [68:0] mout = '0;
  bit          mov = 1'b0;
  bit          mdrop = 1'b0;
  int unsigned mpkt = 0, merr = 0, movf = 0;

  int   checks = 0;
  int   errors = 0;
  int   obsBeats = 0;
  int   readyMode = 0;
  logic readyHold = 1'b1;
  logic readyToggle = 1'b0;
  bit   randClear = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    bit full, fire;
    logic [68:0] e;
    if (reset) begin
      q.delete();
      pend.delete();
      mdrop = 1'b0;
      mov   = 1'b0;
      mpkt  = 0;
      merr  = 0;
      movf  = 0;
      return;
    end
    full = (q.size() + pend.size()) == CAP;
    fire = (q.size() > 0) && (!mov || m_tready);
    e    = {s_tlast, 1'b0, s_tuser[2:0], s_tdata};
    if (fire) begin
      mout = q.pop_front();
      mov  = 1'b1;
    end else if (m_tready) begin
      mov = 1'b0;
    end
    if (s_tvalid) begin
      if (mdrop) begin
        if (s_tlast) begin
          pend.delete();
          movf++;
          mdrop = 1'b0;
        end
      end else if (full) begin
        if (s_tlast) begin
          pend.delete();
          movf++;
        end else begin
          mdrop = 1'b1;
        end
      end else if (!s_tlast) begin
        pend.push_back(e);
      end else if (!s_tuser[3]) begin
        pend.push_back(e);
        foreach (pend[i]) q.push_back(pend[i]);
        pend.delete();
        mpkt++;
      end else begin
        pend.delete();
        merr++;
      end
    end
    if (clear_stats) begin
      mpkt = 0;
      merr = 0;
      movf = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("s_tready", 64'(s_tready), 64'(!reset));
    checkOutput("m_tvalid", 64'(m_tvalid), 64'(mov));
    if (mov) begin
      checkOutput("m_tdata", m_tdata, mout[63:0]);
      checkOutput("m_tuser", 64'(m_tuser), 64'(mout[67:64]));
      checkOutput("m_tlast", 64'(m_tlast), 64'(mout[68]));
    end
    checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(mpkt));
    checkOutput("drop_err_cnt", 64'(drop_err_cnt), 64'(merr));
    checkOutput("drop_ovf_cnt", 64'(drop_ovf_cnt), 64'(movf));
  endtask

  task automatic getReady(output logic r);
    case (readyMode)
      0:       r = readyHold;
      1:       begin readyToggle = ~readyToggle; r = readyToggle; end
      default: r = ($urandom_range(0, 9) < 7);
    endcase
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge, check at the next fall.
  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [3:0] u,
                               input logic l, input logic rdy, input logic clr, input logic rst);
    s_tvalid    = v;
    s_tdata     = d;
    s_tuser     = u;
    s_tlast     = l;
    m_tready    = rdy;
    clear_stats = clr;
    reset       = rst;
    if (m_tvalid && m_tready && !reset) obsBeats++;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idle(input int n);
    logic r;
    for (int i = 0; i < n; i++) begin
      getReady(r);
      applyStimulus(1'b0, {$urandom, $urandom}, 4'($urandom), 1'($urandom), r, 1'b0, 1'b0);
    end
  endtask

  task automatic sendFrame(input int len, input logic [2:0] nb, input bit err, input bit clrLast);
    logic r, last, clr;
    logic [3:0] u;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      u    = last ? {err, nb} : 4'($urandom);
      clr  = (last && clrLast) || (randClear && ($urandom_range(0, 49) == 0));
      getReady(r);
      applyStimulus(1'b1, {$urandom, $urandom}, u, last, r, clr, 1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

    $display("[TB] single good frame");
    readyMode = 0; readyHold = 1'b1;
    obsBeats = 0;
    sendFrame(4, 3'd5, 1'b0, 1'b0);
    checkOutput("lat_n1_tvalid", 64'(m_tvalid), 64'd0);
    idle(1);
    checkOutput("lat_n2_tvalid", 64'(m_tvalid), 64'd1);
    idle(6);
    checkOutput("single_beats", 64'(obsBeats), 64'd4);
    checkOutput("single_pkt", 64'(pkt_cnt), 64'd1);

    $display("[TB] error frame then good frame");
    obsBeats = 0;
    sendFrame(3, 3'd0, 1'b1, 1'b0);
    sendFrame(2, 3'd2, 1'b0, 1'b0);
    idle(6);
    checkOutput("err_beats", 64'(obsBeats), 64'd2);
    checkOutput("err_drop_cnt", 64'(drop_err_cnt), 64'd1);
    checkOutput("err_pkt", 64'(pkt_cnt), 64'd2);

    $display("[TB] overflow with stalled output");
    readyHold = 1'b0;
    sendFrame(10, 3'd1, 1'b0, 1'b0);
    sendFrame(8, 3'd4, 1'b0, 1'b0);
    idle(4);
    checkOutput("ovf_cnt", 64'(drop_ovf_cnt), 64'd1);
    obsBeats = 0;
    readyHold = 1'b1;
    idle(20);
    checkOutput("ovf_beats", 64'(obsBeats), 64'd10);

    $display("[TB] oversize frame");
    obsBeats = 0;
    sendFrame(20, 3'd0, 1'b0, 1'b0);
    idle(4);
    checkOutput("big_beats", 64'(obsBeats), 64'd0);
    checkOutput("big_ovf_cnt", 64'(drop_ovf_cnt), 64'd2);
    sendFrame(3, 3'd7, 1'b0, 1'b0);
    idle(6);
    checkOutput("big_next_beats", 64'(obsBeats), 64'd3);

    $display("[TB] toggled backpressure");
    obsBeats = 0;
    readyMode = 1;
    for (int f = 0; f < 3; f++) sendFrame(5, 3'(f + 1), 1'b0, 1'b0);
    idle(40);
    checkOutput("bp_beats", 64'(obsBeats), 64'd15);

    $display("[TB] clear_stats and reset");
    readyMode = 0; readyHold = 1'b1;
    sendFrame(2, 3'd3, 1'b0, 1'b1);
    checkOutput("clr_pkt", 64'(pkt_cnt), 64'd0);
    checkOutput("clr_ovf", 64'(drop_ovf_cnt), 64'd0);
    idle(4);
    sendFrame(8, 3'd6, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
    idle(5);
    checkOutput("rst_empty_tvalid", 64'(m_tvalid), 64'd0);

    $display("[TB] random traffic");
    readyMode = 2;
    randClear = 1'b1;
    for (int f = 0; f < 300; f++) begin
      sendFrame($urandom_range(1, 20), 3'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    readyMode = 0; readyHold = 1'b1;
    idle(40);
    checkOutput("drain_tvalid", 64'(m_tvalid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
